// File: rtl/pll_nco_clkgen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators
// with run-time retuning through a two-state config handshake.
module pll_nco_clkgen #(
    parameter int          NUM_CH      = 4,
    parameter int          ACC_W       = 32,
    parameter int          LOCK_CYCLES = 16,
    parameter logic [31:0] DEFAULT_FTW = 32'h80E6_3859
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_ftw,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] locked,
    output logic              locked_all
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_APPLY  = 1'b1;
    localparam logic [15:0]      LOCK_INIT = 16'(LOCK_CYCLES);
    localparam logic [ACC_W-1:0] FTW_INIT  = DEFAULT_FTW[ACC_W-1:0];
    localparam logic [4:0]       NUM_CH_W  = 5'(NUM_CH);

    logic [0:0]       state_q, state_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q, cfg_err_d;
    logic [3:0]       cap_ch_q, cap_ch_d;
    logic [ACC_W-1:0] cap_ftw_q, cap_ftw_d;
    logic [ACC_W-1:0] cap_phase_q, cap_phase_d;

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] acc_d [NUM_CH];
    logic [ACC_W-1:0] ftw_q [NUM_CH];
    logic [ACC_W-1:0] ftw_d [NUM_CH];
    logic [15:0]      cnt_q [NUM_CH];
    logic [15:0]      cnt_d [NUM_CH];
    logic [ACC_W:0]   sum   [NUM_CH];

    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] outclk_q, outclk_d;
    logic [NUM_CH-1:0] locked_q, locked_d;

    logic accept;
    logic apply_hit;

    always_comb begin
        accept      = cfg_valid && cfg_ready_q;
        apply_hit   = (state_q == ST_APPLY) && ({1'b0, cap_ch_q} < NUM_CH_W);
        state_d     = state_q;
        cap_ch_d    = cap_ch_q;
        cap_ftw_d   = cap_ftw_q;
        cap_phase_d = cap_phase_q;
        cfg_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_APPLY;
                    cap_ch_d    = cfg_ch;
                    cap_ftw_d   = cfg_ftw;
                    cap_phase_d = cfg_phase;
                    cfg_err_d   = ({1'b0, cfg_ch} >= NUM_CH_W);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cfg_ready_d = (state_d == ST_IDLE);
    end

    // An apply overrides the normal accumulate step and restarts the lock timer.
    always_comb begin
        ce_d     = '0;
        outclk_d = '0;
        locked_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum[c]   = {1'b0, acc_q[c]} + {1'b0, ftw_q[c]};
            acc_d[c] = acc_q[c];
            ftw_d[c] = ftw_q[c];
            cnt_d[c] = (cnt_q[c] != 16'd0) ? (cnt_q[c] - 16'd1) : cnt_q[c];
            if (ch_en[c]) begin
                acc_d[c] = sum[c][ACC_W-1:0];
                ce_d[c]  = sum[c][ACC_W];
            end
            locked_d[c] = (cnt_q[c] == 16'd0) && ch_en[c];
            if (apply_hit && (cap_ch_q == 4'(c))) begin
                acc_d[c]    = cap_phase_q;
                ftw_d[c]    = cap_ftw_q;
                cnt_d[c]    = LOCK_INIT;
                ce_d[c]     = 1'b0;
                locked_d[c] = 1'b0;
            end
            outclk_d[c] = acc_d[c][ACC_W-1];
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            cap_ch_q    <= '0;
            cap_ftw_q   <= '0;
            cap_phase_q <= '0;
            ce_q        <= '0;
            outclk_q    <= '0;
            locked_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
                ftw_q[c] <= FTW_INIT;
                cnt_q[c] <= LOCK_INIT;
            end
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            cap_ch_q    <= cap_ch_d;
            cap_ftw_q   <= cap_ftw_d;
            cap_phase_q <= cap_phase_d;
            ce_q        <= ce_d;
            outclk_q    <= outclk_d;
            locked_q    <= locked_d;
            acc_q       <= acc_d;
            ftw_q       <= ftw_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign cfg_err    = cfg_err_q;
    assign ce         = ce_q;
    assign outclk     = outclk_q;
    assign locked     = locked_q;
    assign locked_all = &locked_q;

endmodule
